// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants, derived totals and count width
package vga_timing_pkg;
  localparam int CNT_W = 10;
  localparam int CLK_DIV_DEF = 4;
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF = 33;
  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
endpackage

// File: rtl/vga_pix_div.sv
// vga_pix_div: clock-enable divider, tick high during the last clk of each CLK_DIV period
module vga_pix_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int DW = $clog2(CLK_DIV);
  logic [DW-1:0] div;
  assign tick = div == DW'(CLK_DIV - 1);
  always_ff @(posedge clk)
    div <= rst || tick ? '0 : div + 1'b1;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, sync/bright decode and strobes
// VGA_SYNC_DELAY_EN adds one register stage on hSync/vSync to match a registered pixel path.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             bright,
  output logic             hSync,
  output logic             vSync,
  output logic             pix_tick,
  output logic             frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_VISIBLE + V_FP + V_SYNC);
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 2");
  end
  logic tick, hs_r, vs_r;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_div (.clk(clk), .rst(rst), .tick(tick));
  // Qualifiers decode the next counts so they register on the same edge as the counts.
  always_comb begin
    h_nxt = tick ? (hCount == H_LAST ? '0 : hCount + 1'b1) : hCount;
    v_nxt = tick && hCount == H_LAST ? (vCount == V_LAST ? '0 : vCount + 1'b1) : vCount;
  end
  always_ff @(posedge clk)
    if (rst) begin
      hCount <= H_LAST;
      vCount <= V_LAST;
      bright <= 1'b0;
      hs_r <= 1'b1;
      vs_r <= 1'b1;
      pix_tick <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hCount <= h_nxt;
      vCount <= v_nxt;
      bright <= h_nxt < H_VIS && v_nxt < V_VIS;
      hs_r <= !(h_nxt >= HS_BEG && h_nxt < HS_END);
      vs_r <= !(v_nxt >= VS_BEG && v_nxt < VS_END);
      pix_tick <= tick;
      frame_start <= tick && h_nxt == '0 && v_nxt == '0;
    end
`ifdef VGA_SYNC_DELAY_EN
  always_ff @(posedge clk)
    {hSync, vSync} <= rst ? 2'b11 : {hs_r, vs_r};
`else
  assign hSync = hs_r;
  assign vSync = vs_r;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of reset, line, frame, wrap and mid-frame reset
module tb_vga_timing_gen;
  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] h, v, b_h, b_v;
  logic br, hs, vs, pt, fs, b_br, b_hs, b_vs, b_pt, b_fs;
  int n_cmp = 0, n_bad = 0;
`ifdef VGA_SYNC_DELAY_EN
  localparam int SYNC_LAT = 1;
`else
  localparam int SYNC_LAT = 0;
`endif
  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk(clk), .rst(rst), .hCount(h), .vCount(v), .bright(br), .hSync(hs),
    .vSync(vs), .pix_tick(pt), .frame_start(fs)
  );
  // Small raster: 15x10 totals, 2 clks/pixel, 300 clks/frame
  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clk(clk), .rst(rst), .hCount(b_h), .vCount(b_v), .bright(b_br), .hSync(b_hs),
    .vSync(b_vs), .pix_tick(b_pt), .frame_start(b_fs)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(5);
    n_cmp++; if (h !== 10'd799) begin n_bad++; $display("FAIL rst_h got %0d exp 799", h); end
    n_cmp++; if (v !== 10'd524) begin n_bad++; $display("FAIL rst_v got %0d exp 524", v); end
    n_cmp++; if ({br, hs, vs, pt, fs} !== 5'b01100) begin n_bad++; $display("FAIL rst_flags got %b exp 01100", {br, hs, vs, pt, fs}); end
    rst = 1'b0;
    step(3);
    n_cmp++; if (pt !== 1'b0 || h !== 10'd799) begin n_bad++; $display("FAIL early_tick pt %b h %0d exp 0/799", pt, h); end
    step(1);
    n_cmp++; if (h !== 10'd0 || v !== 10'd0) begin n_bad++; $display("FAIL first_adv h %0d v %0d exp 0/0", h, v); end
    n_cmp++; if ({br, pt, fs} !== 3'b111) begin n_bad++; $display("FAIL first_strobes got %b exp 111", {br, pt, fs}); end
  endtask

  task automatic test_line;
    int t656 = -1, tfall = -1, hfall = -1, hrise = -1, bfall = -1, low = 0, bcnt = 0, ticks = 0, hmax = 0;
    logic phs = hs, pbr = br;
    for (int k = 1; k <= 3200; k++) begin
      step(1);
      if (h == 10'd656 && t656 < 0) t656 = k;
      if (phs && !hs && tfall < 0) begin tfall = k; hfall = int'(h); end
      if (!phs && hs && hrise < 0) hrise = int'(h);
      if (pbr && !br && bfall < 0) bfall = int'(h);
      low += int'(!hs);
      bcnt += int'(br);
      ticks += int'(pt);
      if (int'(h) > hmax) hmax = int'(h);
      phs = hs;
      pbr = br;
    end
    n_cmp++; if (hfall != 656) begin n_bad++; $display("FAIL hs_fall_h got %0d exp 656", hfall); end
    n_cmp++; if (hrise != 752) begin n_bad++; $display("FAIL hs_rise_h got %0d exp 752", hrise); end
    n_cmp++; if (tfall - t656 != SYNC_LAT) begin n_bad++; $display("FAIL hs_lat got %0d exp %0d", tfall - t656, SYNC_LAT); end
    n_cmp++; if (low != 384) begin n_bad++; $display("FAIL hs_low got %0d exp 384", low); end
    n_cmp++; if (bfall != 640) begin n_bad++; $display("FAIL br_fall_h got %0d exp 640", bfall); end
    n_cmp++; if (bcnt != 2560) begin n_bad++; $display("FAIL br_clks got %0d exp 2560", bcnt); end
    n_cmp++; if (ticks != 800) begin n_bad++; $display("FAIL line_ticks got %0d exp 800", ticks); end
    n_cmp++; if (hmax != 799) begin n_bad++; $display("FAIL h_max got %0d exp 799", hmax); end
    n_cmp++; if (h !== 10'd0 || v !== 10'd1) begin n_bad++; $display("FAIL line_end h %0d v %0d exp 0/1", h, v); end
  endtask

  task automatic test_frame;
    int guard = 0, fcnt = 0, vlow = 0, bcnt = 0, hmax = 0, vmax = 0;
    logic [9:0] ph, pv;
    while (!b_fs && guard < 400) begin step(1); guard++; end
    n_cmp++; if (!b_fs) begin n_bad++; $display("FAIL small_fs_wait got none exp pulse within 400 clks"); end
    for (int k = 1; k <= 300; k++) begin
      ph = b_h;
      pv = b_v;
      step(1);
      if (b_fs) begin
        fcnt++;
        n_cmp++; if (ph !== 10'd14 || pv !== 10'd9 || !b_pt) begin n_bad++; $display("FAIL wrap prev %0d,%0d pt %b exp 14,9 pt 1", ph, pv, b_pt); end
        n_cmp++; if (k != 300) begin n_bad++; $display("FAIL fs_period got %0d exp 300", k); end
      end
      vlow += int'(!b_vs);
      bcnt += int'(b_br);
      if (int'(b_h) > hmax) hmax = int'(b_h);
      if (int'(b_v) > vmax) vmax = int'(b_v);
    end
    n_cmp++; if (fcnt != 1) begin n_bad++; $display("FAIL fs_count got %0d exp 1", fcnt); end
    n_cmp++; if (vlow != 60) begin n_bad++; $display("FAIL vs_low got %0d exp 60", vlow); end
    n_cmp++; if (bcnt != 96) begin n_bad++; $display("FAIL frame_bright got %0d exp 96", bcnt); end
    n_cmp++; if (hmax != 14 || vmax != 9) begin n_bad++; $display("FAIL count_max got %0d,%0d exp 14,9", hmax, vmax); end
  endtask

  task automatic test_mid_reset;
    int guard = 0, ticks = 0, moved = 0;
    while (h != 10'd700 && guard < 4000) begin step(1); guard++; end
    n_cmp++; if (h !== 10'd700 || hs !== 1'b0) begin n_bad++; $display("FAIL pre_rst h %0d hs %b exp 700/0", h, hs); end
    rst = 1'b1;
    step(1);
    n_cmp++; if (hs !== 1'b1 || vs !== 1'b1) begin n_bad++; $display("FAIL rst_sync hs %b vs %b exp 1/1", hs, vs); end
    n_cmp++; if (h !== 10'd799 || v !== 10'd524) begin n_bad++; $display("FAIL rst_cnt h %0d v %0d exp 799/524", h, v); end
    n_cmp++; if ({br, pt, fs} !== 3'b000) begin n_bad++; $display("FAIL rst_strobes got %b exp 000", {br, pt, fs}); end
    for (int k = 0; k < 10; k++) begin
      step(1);
      ticks += int'(pt) + int'(b_pt);
      moved += int'(h != 10'd799) + int'(b_h != 10'd14);
    end
    n_cmp++; if (ticks != 0) begin n_bad++; $display("FAIL held_ticks got %0d exp 0", ticks); end
    n_cmp++; if (moved != 0) begin n_bad++; $display("FAIL held_moves got %0d exp 0", moved); end
    rst = 1'b0;
    step(4);
    n_cmp++; if (h !== 10'd0 || v !== 10'd0 || fs !== 1'b1) begin n_bad++; $display("FAIL rerelease h %0d v %0d fs %b exp 0/0/1", h, v, fs); end
  endtask

  initial begin
    test_reset;
    test_line;
    test_frame;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640×480 @ 60 Hz VGA raster timing from the 100 MHz system clock. Produces the `hCount`/`vCount`/`bright` stream consumed by the Mastermind pixel renderer, the active-low `hSync`/`vSync` pins, and per-pixel and per-frame strobes. It sits at the top level between the board clock and the renderer/DAC path.

## Interface
- `CLK_DIV`, 4: system clocks per pixel; must be ≥2.
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_VISIBLE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.
- Derived totals: `H_TOTAL` = sum of H terms (800), `V_TOTAL` = sum of V terms (525). Both must be ≤1024; elaboration error otherwise.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: synchronous, active-high reset.
- `hCount` out 10: pixel column, 0..H_TOTAL-1.
- `vCount` out 10: line, 0..V_TOTAL-1.
- `bright` out 1: high iff hCount<H_VISIBLE and vCount<V_VISIBLE.
- `hSync` out 1: active-low horizontal sync.
- `vSync` out 1: active-low vertical sync.
- `pix_tick` out 1: one-clk pulse when counters take a new value.
- `frame_start` out 1: one-clk pulse when counters become (0,0).

## Operation
- Divider counter `div` counts 0..CLK_DIV-1 and wraps. When `div`==CLK_DIV-1, the pixel advances.
- On each advance, `hCount` increments. At H_TOTAL-1 it wraps to 0 and `vCount` increments. At V_TOTAL-1, `vCount` wraps to 0.
- Counting origin is the first visible pixel. Each line runs visible → front porch → sync → back porch.
- `hSync` is low iff hCount ∈ [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC), which is [656,752) with defaults.
- `vSync` is low iff vCount ∈ [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC), which is [490,492) with defaults.
- All outputs are registered. `bright`, `hSync`, `vSync` are decoded from the next counter values, so they change in the same clk edge as `hCount`/`vCount`. There is no skew between count and qualifiers.
- `pix_tick` is high in the clk where the new counter values first appear.
- `frame_start` is high in the clk where the counters first show (0,0). It is coincident with that `pix_tick`.

## Timing
- Reset values: `div`=0, `hCount`=H_TOTAL-1 (799), `vCount`=V_TOTAL-1 (524), `bright`=0, `hSync`=1, `vSync`=1, `pix_tick`=0, `frame_start`=0.
- First advance after reset release is on the CLK_DIV-th clk edge. It wraps to (0,0) with `bright`=1, `pix_tick`=1, `frame_start`=1.
- Each count value is held for exactly CLK_DIV clks.
- Line period is H_TOTAL·CLK_DIV = 3200 clks. Frame period is 3200·525 = 1,680,000 clks.
- `rst` asserted mid-frame: on the next edge, all state returns to reset values regardless of `div`. No partial sync pulse is extended; `hSync`/`vSync` go high immediately.
- `rst` held: outputs remain at reset values and no ticks are produced.
- Line and frame wrap in the same advance (799,524)→(0,0): both wraps occur in one edge.

## Configuration
- `VGA_SYNC_DELAY_EN` defined: `hSync` and `vSync` pass through one extra register stage, enabled on every clk, delaying them by exactly 1 clk. This aligns them with the renderer's registered `vgaR/G/B`, which lag `hCount` by one clk. `bright`, counts, and strobes are unchanged.
- `VGA_SYNC_DELAY_EN` undefined: syncs are coincident with the counts as stated in Operation.
- The extra stage resets to 1.

## Structure
- Shared package `vga_timing_pkg`: default 640×480 timing constants, derived H_TOTAL/V_TOTAL, and the 10-bit count width.
- One sub-module `vga_pix_div`: parameterised clock-enable divider with `clk`, `rst`, and output `tick`.
- Counters, decode, and output registers stay in `vga_timing_gen`.

## Test plan
- Reset release: hold `rst` 5 clks, release → first `pix_tick` on the 4th clk after release with hCount=0, vCount=0, bright=1, frame_start=1.
- Line timing: run one line → hSync falls when hCount=656, rises when hCount=752. Low duration = 96·4 = 384 clks. bright falls when hCount=640.
- Frame timing: run one full frame → vSync low only for vCount 490–491, i.e. 6400 clks. frame_start pulses exactly once per 1,680,000 clks. Visible bright clks per frame = 640·480·4.
- Wrap: observe (799,524)→(0,0) in one pix_tick. vCount never reaches 525; hCount never reaches 800.
- Mid-operation reset: assert `rst` at hCount=700 (in sync) → next edge gives hSync=1, hCount=799, vCount=524, no pix_tick while held.
- Macro: build with `VGA_SYNC_DELAY_EN` → hSync falls 1 clk after hCount becomes 656. Without it, the fall is in the same clk.
